// File: rtl/mux_4x1_rr.sv
// Four-channel round-robin collector: merges four valid/ready streams into one
// registered output stream tagged with its source channel on s.
module mux_4x1_rr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*WIDTH-1:0] i,
  input  logic [3:0]         in_valid,
  output logic [3:0]         in_ready,
  output logic [WIDTH-1:0]   y,
  output logic [1:0]         s,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  logic [WIDTH-1:0] y_q, y_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load;
  logic             gnt_found;
  logic             take;
  logic [SEL_W-1:0] gnt;
  logic [SEL_W-1:0] cand;

  // Arbitration and next-state: first valid channel starting at ptr wins.
  always_comb begin
    load        = !out_valid_q || out_ready;
    gnt_found   = 1'b0;
    gnt         = '0;
    cand        = ptr_q;
    in_ready    = '0;
    y_d         = y_q;
    s_d         = s_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;

    for (int unsigned k = 0; k < N_CH; k++) begin
      cand = ptr_q + SEL_W'(k);
      if (!gnt_found && in_valid[cand]) begin
        gnt_found = 1'b1;
        gnt       = cand;
      end
    end

    take = load && gnt_found && !rst;
    if (take) begin
      in_ready[gnt] = 1'b1;
    end

    // A load slot with nothing granted drains the output; data and ptr hold.
    if (load) begin
      out_valid_d = gnt_found;
      if (gnt_found) begin
        y_d   = i[WIDTH*32'(gnt) +: WIDTH];
        s_d   = gnt;
        ptr_d = gnt + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      y_q         <= y_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign y         = y_q;
  assign s         = s_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/mux_4x1_rr.md
Name: mux_4x1_rr

Overview:
- Four-channel round-robin collector. The converse of the 1x4 demux: merges four valid/ready input streams into one registered output stream.
- Each output word carries a 2-bit select `s` naming its source channel, so a downstream 1x4 demux can route it back out without extra decoding.
- Sits between per-channel producers and a single shared link or sink.

Parameters:
- WIDTH, 8, data width of each input channel and of output y.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- i  input  4*WIDTH  packed channel data; channel n is i[n*WIDTH +: WIDTH].
- in_valid  input  4  per-channel valid.
- in_ready  output  4  per-channel ready; at most one bit high per cycle.
- y  output  WIDTH  registered output data.
- s  output  2  registered source channel of y.
- out_valid  output  1  y/s hold a word.
- out_ready  input  1  downstream accepts a word when out_valid && out_ready.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous, active-high on rst, sampled at the clk rising edge.
  - Reset values: out_valid=0, y=0, s=0, round-robin pointer ptr=0. in_ready is 0 for every cycle rst is high.
- Load enable: `load = !out_valid || out_ready`. The output register takes a new word only when load is 1.
- Arbitration (combinational):
  - When load=1, grant g is the first channel with in_valid set, searching ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - in_ready[g]=1; all other in_ready bits are 0.
  - If no channel is valid, or load=0, in_ready=4'b0000.
  - in_ready depends combinationally on in_valid and out_ready. No combinational path from i to any output.
- Transfer on a channel: occurs when in_valid[n] && in_ready[n]. On the next edge:
  - y <= i[g*WIDTH +: WIDTH];
  - s <= g;
  - out_valid <= 1;
  - ptr <= (g+1) mod 4.
- Latency and throughput:
  - Latency from input accept to out_valid is 1 cycle.
  - Throughput is 1 word per cycle when out_ready is held high.
- Stall (out_valid=1, out_ready=0):
  - y, s, out_valid and ptr hold.
  - in_ready=0.
  - Inputs must hold their data (standard valid/ready rule).
- Drain (load=1 with no valid input):
  - out_valid <= 0.
  - y and s hold their last values; downstream must not interpret them.
  - ptr holds.
- Simultaneous drain and refill:
  - out_valid=1, out_ready=1 and some in_valid set: the current word is consumed and the new word is loaded on the same edge.
  - out_valid stays 1 with no bubble.
- Fairness:
  - A channel that stays valid is granted within 4 accepted transfers.
  - ptr only advances on an accepted transfer.
- Wrap-around: a grant on channel 3 sets ptr=0.
- Reset mid-operation:
  - A pending output word is discarded (out_valid=0) with no handshake.
  - ptr returns to 0.
  - in_ready is 0 during reset.
- Protocol violations (in_valid dropped without handshake) need no defined behaviour beyond ignoring that channel.

Test Plan:
1. Reset then idle: rst high 2 cycles, in_valid=0 -> out_valid=0, y=0, s=0, in_ready=0000 every cycle.
2. Single channel, streaming:
   - Stimulus: only ch2 valid with data 8'hA5, out_ready=1.
   - Response: in_ready=0100. Next cycle y=A5, s=2, out_valid=1. ptr becomes 3.
3. Round-robin, all channels:
   - Stimulus: all 4 channels valid with data 8'h10, 8'h11, 8'h12, 8'h13; out_ready=1.
   - Response: output sequence s=0,1,2,3,0 with y=10,11,12,13,10 on consecutive cycles, no bubbles.
4. Backpressure:
   - Stimulus: ch1=8'h3C valid, out_ready=0 for 3 cycles after the word loads.
   - Response: y=3C, s=1, out_valid=1 stable; in_ready=0000 while stalled. Release out_ready -> word consumed, next grant proceeds.
5. Wrap-around plus simultaneous drain/refill:
   - Stimulus: ptr=3 with ch3 and ch0 valid, out_ready=1.
   - Response: ch3 granted first, then ch0 on the next cycle with out_valid continuously 1.
6. Reset mid-operation:
   - Stimulus: rst asserted while out_valid=1, s=2.
   - Response: next edge out_valid=0, y=0, s=0. After release, with all channels valid, the first grant is ch0.
